// File: rtl/cajero_pkg.sv
// rtl/cajero_pkg.sv - shared state encoding, transaction constants and sizing helper for the cashier controller
package cajero_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        PIN,
        VERIFICA,
        TRANSACCION,
        BLOQUEO
    } estado_t;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Attempt counter must be able to hold MAX_INTENTOS itself.
    function automatic int intentos_w(input int max_intentos);
        return $clog2(max_intentos + 1);
    endfunction

endpackage

// File: rtl/cajero_param_if.sv
// rtl/cajero_param_if.sv - front-end/back-end signal bundle of the cashier controller
interface cajero_param_if #(
    parameter int PIN_DIGITS = 4,
    parameter int MONTO_W    = 32,
    parameter int BALANCE_W  = 64
);
    logic                    tarjeta_recibida;
    logic                    digito_stb;
    logic [3:0]              digito;
    logic [4*PIN_DIGITS-1:0] pin_correcto;
    logic                    tipo_trans;
    logic                    monto_stb;
    logic [MONTO_W-1:0]      monto;
    logic [BALANCE_W-1:0]    balance_inicial;

    logic                    pin_incorrecto;
    logic                    advertencia;
    logic                    bloqueo;
    logic [BALANCE_W-1:0]    balance_actualizado;
    logic                    balance_stb;
    logic                    entregar_dinero;
    logic                    fondos_insuficientes;
    logic                    timeout;

    modport master (
        output tarjeta_recibida, digito_stb, digito, pin_correcto,
               tipo_trans, monto_stb, monto, balance_inicial,
        input  pin_incorrecto, advertencia, bloqueo, balance_actualizado,
               balance_stb, entregar_dinero, fondos_insuficientes, timeout
    );

    modport slave (
        input  tarjeta_recibida, digito_stb, digito, pin_correcto,
               tipo_trans, monto_stb, monto, balance_inicial,
        output pin_incorrecto, advertencia, bloqueo, balance_actualizado,
               balance_stb, entregar_dinero, fondos_insuficientes, timeout
    );
endinterface

// File: rtl/cajero_pin_captura.sv
// rtl/cajero_pin_captura.sv - MS-first BCD digit shift register with digit counter (PIN_DIGITS >= 2)
module cajero_pin_captura
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    limpiar,
    input  logic                    desplazar,
    input  logic [3:0]              digito,
    output logic                    pin_completo,
    output logic [4*PIN_DIGITS-1:0] pin_capturado
);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    logic [CNT_W-1:0] cuenta;

    // High in the cycle whose strobe delivers the final digit.
    assign pin_completo = desplazar && (cuenta == CNT_W'(PIN_DIGITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta        <= '0;
            pin_capturado <= '0;
        end else if (limpiar) begin
            cuenta        <= '0;
            pin_capturado <= '0;
        end else if (desplazar) begin
            cuenta        <= cuenta + 1'b1;
            pin_capturado <= {pin_capturado[4*PIN_DIGITS-5:0], digito};
        end
    end

endmodule

// File: rtl/cajero_param.sv
// rtl/cajero_param.sv - cashier controller top: FSM, attempts, arithmetic; idle abort under CAJERO_TIMEOUT_EN
module cajero_param
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int MONTO_W      = 32,
    parameter int BALANCE_W    = 64,
    parameter int TIMEOUT_CYC  = 1024
)(
    input  logic          clk,
    input  logic          reset,
    cajero_param_if.slave bus
);
    localparam int INT_W = intentos_w(MAX_INTENTOS);

    estado_t                 estado;
    logic [INT_W-1:0]        intentos;
    logic [INT_W-1:0]        intentos_sig;
    logic                    pin_completo;
    logic [4*PIN_DIGITS-1:0] pin_capturado;
    logic                    tmo_fire;
    logic [BALANCE_W-1:0]    monto_ext;
    logic [BALANCE_W:0]      suma;

    assign intentos_sig = intentos + 1'b1;
    assign monto_ext    = BALANCE_W'(bus.monto);
    assign suma         = {1'b0, bus.balance_inicial} + {1'b0, monto_ext};

    cajero_pin_captura #(.PIN_DIGITS(PIN_DIGITS)) u_captura (
        .clk           (clk),
        .reset         (reset),
        .limpiar       ((estado != PIN) || tmo_fire),
        .desplazar     ((estado == PIN) && bus.digito_stb),
        .digito        (bus.digito),
        .pin_completo  (pin_completo),
        .pin_capturado (pin_capturado)
    );

`ifdef CAJERO_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] inactivo;
    logic             activo;
    logic             strobe;

    assign activo   = (estado == PIN) || (estado == TRANSACCION);
    assign strobe   = bus.digito_stb || bus.monto_stb;
    assign tmo_fire = activo && !strobe && (inactivo == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inactivo <= '0;
        end else if (!activo || strobe || tmo_fire) begin
            inactivo <= '0;
        end else begin
            inactivo <= inactivo + 1'b1;
        end
    end
`else
    // Constant-false expression keeps TIMEOUT_CYC referenced in this build.
    assign tmo_fire = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado                   <= ESPERA_TARJETA;
            intentos                 <= '0;
            bus.pin_incorrecto       <= 1'b0;
            bus.advertencia          <= 1'b0;
            bus.bloqueo              <= 1'b0;
            bus.balance_actualizado  <= '0;
            bus.balance_stb          <= 1'b0;
            bus.entregar_dinero      <= 1'b0;
            bus.fondos_insuficientes <= 1'b0;
            bus.timeout              <= 1'b0;
        end else begin
            bus.pin_incorrecto       <= 1'b0;
            bus.balance_stb          <= 1'b0;
            bus.entregar_dinero      <= 1'b0;
            bus.fondos_insuficientes <= 1'b0;
            bus.timeout              <= 1'b0;
            case (estado)
                ESPERA_TARJETA: begin
                    if (bus.tarjeta_recibida) estado <= PIN;
                end
                PIN: begin
                    if (tmo_fire) begin
                        bus.timeout <= 1'b1;
                        estado      <= ESPERA_TARJETA;
                    end else if (pin_completo) begin
                        estado <= VERIFICA;
                    end
                end
                VERIFICA: begin
                    if (pin_capturado == bus.pin_correcto) begin
                        intentos        <= '0;
                        bus.advertencia <= 1'b0;
                        estado          <= TRANSACCION;
                    end else begin
                        bus.pin_incorrecto <= 1'b1;
                        intentos           <= intentos_sig;
                        if (intentos_sig == INT_W'(MAX_INTENTOS)) begin
                            bus.bloqueo     <= 1'b1;
                            bus.advertencia <= 1'b0;
                            estado          <= BLOQUEO;
                        end else begin
                            if (intentos_sig == INT_W'(MAX_INTENTOS - 1)) bus.advertencia <= 1'b1;
                            estado <= PIN;
                        end
                    end
                end
                TRANSACCION: begin
                    if (tmo_fire) begin
                        bus.timeout <= 1'b1;
                        estado      <= ESPERA_TARJETA;
                    end else if (bus.monto_stb) begin
                        estado <= ESPERA_TARJETA;
                        if (bus.tipo_trans == DEPOSITO) begin
                            bus.balance_actualizado <= suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                            bus.balance_stb         <= 1'b1;
                        end else if (monto_ext <= bus.balance_inicial) begin
                            bus.balance_actualizado <= bus.balance_inicial - monto_ext;
                            bus.balance_stb         <= 1'b1;
                            bus.entregar_dinero     <= 1'b1;
                        end else begin
                            bus.fondos_insuficientes <= 1'b1;
                        end
                    end
                end
                BLOQUEO: estado <= BLOQUEO;
                default: estado <= ESPERA_TARJETA;
            endcase
        end
    end

endmodule
